// File: rtl/uart_rx_if.sv
// CPU memory-bus slice seen by the UART receiver. mem_ready/mem_rdata are shared
// tri-state nets, so they are declared as wires that several peripherals may drive.
interface uart_rx_if;
    logic        enable;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    wire         mem_ready;
    wire  [31:0] mem_rdata;

    modport master (
        output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a receive FIFO and a memory-mapped data/status interface.
// Offset 0x0 pops the FIFO head, offset 0x4 holds {full, FERR, OVR, not_empty}.
module uart_rx #(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     serialIn,
    uart_rx_if.slave bus
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV - 1);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    logic          r_sync1;
    logic          r_sync2;
    rx_state_t     r_state;
    logic [15:0]   r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovr;
    logic          r_ferr;

    logic          r_ack;
    logic          r_ack_we;
    logic [1:0]    r_ack_off;
    logic [1:0]    r_ack_clr;

    logic          w_rxs;
    logic          w_expired;
    logic          w_push;
    logic          w_ferr_set;
    logic          w_full;
    logic          w_not_empty;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_ovr_set;
    logic          w_flag_wr;
    logic          w_req;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_rxs       = r_sync2;
    assign w_expired   = (r_timer == 16'd0);
    assign w_push      = (r_state == S_STOP) && w_expired && w_rxs;
    assign w_ferr_set  = (r_state == S_STOP) && w_expired && !w_rxs;
    assign w_full      = (r_count == DEPTH_C);
    assign w_not_empty = (r_count != '0);
    assign w_pop       = r_ack && !r_ack_we && (r_ack_off == 2'd0) && w_not_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_ovr_set   = w_push && w_full && !w_pop;
    assign w_flag_wr   = r_ack && r_ack_we && (r_ack_off == 2'd1);
    assign w_req       = bus.mem_valid && bus.enable && !r_ack;

    assign w_unused = ^{bus.mem_instr, bus.mem_addr[31:4], bus.mem_addr[1:0],
                        bus.mem_wdata[31:3], bus.mem_wdata[0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make this a true two-stage shift; blocking would collapse it to one flop.
            r_sync1 <= serialIn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_timer <= HALF_BIT;
                    end
                end
                S_START: begin
                    if (!w_expired) begin
                        r_timer <= r_timer - 16'd1;
                    end else if (!w_rxs) begin
                        r_state   <= S_DATA;
                        r_timer   <= FULL_BIT;
                        r_bit_idx <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_expired) begin
                        r_timer <= r_timer - 16'd1;
                    end else begin
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_timer <= FULL_BIT;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (!w_expired) begin
                        r_timer <= r_timer - 16'd1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Receiver events take priority over a software clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (w_flag_wr && r_ack_clr[0]) begin
                r_ovr <= 1'b0;
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end else if (w_flag_wr && r_ack_clr[1]) begin
                r_ferr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ack     <= 1'b0;
            r_ack_we  <= 1'b0;
            r_ack_off <= '0;
            r_ack_clr <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_ack_we  <= |bus.mem_wstrb;
                r_ack_off <= bus.mem_addr[3:2];
                r_ack_clr <= bus.mem_wdata[2:1];
            end
        end
    end

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        w_rdata = '0;
        if (!r_ack_we) begin
            unique case (r_ack_off)
                2'd0: begin
                    if (w_not_empty) begin
                        w_rdata[7:0] = r_mem[r_rd_ptr];
                    end
                end
                2'd1:    w_rdata[3:0] = {w_full, r_ferr, r_ovr, w_not_empty};
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.mem_ready = r_ack ? 1'b1 : 1'bz;
    assign bus.mem_rdata = r_ack ? w_rdata : {32{1'bz}};
endmodule
